seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
// - Display-side consumer of the CPU controller's four-nibble display bus (display_out[3:0]).
// - Time-multiplexes the four hex nibbles onto a 4-digit common-anode 7-segment display.
// - Inserts a blanking gap between digits to remove ghosting.
// - Samples each nibble only at the start of its slot, so mid-slot bus changes never tear a digit.
// PARAMETERS
// REFRESH_DIV   100000  cycles per digit slot (1 kHz/digit at 100 MHz); must exceed BLANK_CYCLES
// BLANK_CYCLES  1000    cycles at slot start with all anodes off; must be >= 1
// ACTIVE_LOW    1       1: an/seg/dp driven active-low; 0: active-high
// PORTS
// clk        in   1      clock
// reset      in   1      reset, synchronous, active-high
// digit_in   in   4x4    unpacked [3:0] nibbles; digit_in[k] drives digit k (k=0 rightmost)
// digit_en   in   4      per-digit enable; 0 keeps that anode off for its whole slot
// dp_in      in   4      per-digit decimal point request
// freeze     in   1      1: hold the shadow copy; digit_in changes are ignored
// an         out  4      anode drives, one-hot-active during DRIVE
// seg        out  7      {g,f,e,d,c,b,a}
// dp         out  1      decimal point
// scan_idx   out  2      digit index of the current slot
// BEHAVIOUR
// - Reset (sync, overrides all else):
//   - an, seg, dp all inactive (ACTIVE_LOW=1: 4'b1111, 7'h7F, 1).
//   - scan_idx=0, state=BLANK, counter=0, shadow regs cleared to 0.
// - FSM, 2 states, one cycle counter cnt:
//   - BLANK: all anodes inactive for BLANK_CYCLES cycles.
//     - On the last BLANK cycle, if freeze=0, sample shadow[scan_idx] <= digit_in[scan_idx] and dp_in[scan_idx].
//     - Go to DRIVE.
//   - DRIVE: for REFRESH_DIV-BLANK_CYCLES cycles:
//     - an[scan_idx] active, other anodes inactive; anode stays off if digit_en[scan_idx]=0.
//     - seg = hex decode of shadow[scan_idx]; dp from the sampled dp bit.
//     - At slot end: scan_idx wraps 3->0 (+1 mod 4), cnt=0, state -> BLANK.
// - Timing:
//   - Slot = REFRESH_DIV cycles exactly; frame = 4*REFRESH_DIV cycles.
//   - Disabled digits still consume their slot; frame timing is constant.
// - Outputs are registered.
//   - First DRIVE cycle after reset: an changes at cycle BLANK_CYCLES+1 after reset release.
// - Digit and freeze sampling:
//   - digit_en is sampled combinationally into the an register each DRIVE cycle.
//   - A digit_en change takes effect the next cycle.
//   - freeze asserted exactly on the sampling cycle holds the old value.
// - Hex decode (ACTIVE_LOW=1), seg values:
//   - 0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
//   - 8:00  9:10  A:08  b:03  C:46  d:21  E:06  F:0E
//   - ACTIVE_LOW=0 uses the bitwise inverse.
// - Reset mid-DRIVE: next edge blanks all outputs, restarts at slot 0 BLANK.
// STRUCTURE
// - Shared display package: segment encoding localparams (SEG_OFF, hex table) and the scan state enum.
//   - The same package serves any future display blocks.
// - One sub-module hex_to_seg: combinational nibble -> 7-bit active-high code.
//   - The scanner applies the ACTIVE_LOW polarity.
// TESTING (bench params REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1; frame=32 cycles)
// - Reset held 3 cycles then released.
//   - an=4'b1111, seg=7'h7F, dp=1, scan_idx=0 during reset and for 2 cycles after.
//   - Then an=4'b1110 for 6 cycles.
// - digit_in={F,A,1,0}, digit_en=4'b1111.
//   - Slot order an=1110/1101/1011/0111 with seg=40/79/08/0E.
//   - Each slot is preceded by 2 cycles of an=1111; pattern repeats every 32 cycles.
// - Change digit_in[0] from 0 to 8 in the middle of slot 0.
//   - seg stays 7'h40 for the rest of the slot.
//   - The next frame's slot 0 shows 7'h00.
// - freeze=1, then change all digit_in: displayed codes unchanged for 2 frames.
//   - Drop freeze: new values appear in each digit's next slot.
// - digit_en=4'b0101.
//   - Slots 1 and 3 show an=1111 for all 8 cycles.
//   - Slots 0 and 2 still drive; frame still 32 cycles.
//   - dp_in=4'b0001 -> dp=0 only during slot 0 DRIVE.
// - Assert reset on the 4th DRIVE cycle of slot 2.
//   - Next cycle: all outputs inactive, scan_idx=0.
//   - an=1110 again after 2 blank cycles following release.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions: the scan state encoding and the active-high hex segment table.
// The table is indexed by nibble value and returns the {g,f,e,d,c,b,a} code.
package seven_seg_scanner_pkg;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_DRIVE = 1'b1
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [6:0] HEX_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus coming from the CPU controller: four nibbles plus per-digit enable,
// decimal-point request and a freeze control that pins the displayed values.
interface seven_seg_scanner_if;
   logic [3:0] digit_in [4];
   logic [3:0] digit_en;
   logic [3:0] dp_in;
   logic       freeze;

   modport master (output digit_in, digit_en, dp_in, freeze);
   modport slave  (input  digit_in, digit_en, dp_in, freeze);
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Nibble to active-high 7-segment code; the scanner applies display polarity.
module seven_seg_scanner_hex_to_seg
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] code
);
   always_comb begin
      code = HEX_TABLE[nibble];
   end
endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with a blanking gap before each digit slot.
// Each nibble is captured into a shadow register on the last blank cycle of its slot.
//
// state      | meaning
// SCAN_BLANK | all anodes off; last cycle captures the slot's nibble and dp bit
// SCAN_DRIVE | selected anode on (if enabled), segments show the captured nibble
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   seven_seg_scanner_if.slave   bus,
   output logic [3:0]           an,
   output logic [6:0]           seg,
   output logic                 dp,
   output logic [1:0]           scan_idx
);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

   scan_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       idx_nxt;
   logic             sample;
   logic [3:0]       shadow [4];
   logic [3:0]       shadow_dp;
   logic [6:0]       code;
   logic [3:0]       an_act;
   logic [6:0]       seg_act;
   logic             dp_act;

   seven_seg_scanner_hex_to_seg u_hex (
      .nibble (shadow[scan_idx]),
      .code   (code)
   );

   // The counter runs across the whole slot, so slot length is fixed regardless of enables.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = scan_idx;
      sample    = 1'b0;
      case (state)
         SCAN_BLANK: begin
            if (cnt == BLANK_LAST) begin
               sample    = 1'b1;
               state_nxt = SCAN_DRIVE;
            end
         end
         SCAN_DRIVE: begin
            if (cnt == SLOT_LAST) begin
               cnt_nxt   = '0;
               idx_nxt   = scan_idx + 2'd1;
               state_nxt = SCAN_BLANK;
            end
         end
         default: state_nxt = SCAN_BLANK;
      endcase
   end

   always_comb begin
      an_act  = 4'b0000;
      seg_act = SEG_OFF;
      dp_act  = 1'b0;
      if (state == SCAN_DRIVE) begin
         an_act[scan_idx] = bus.digit_en[scan_idx];
         seg_act          = code;
         dp_act           = shadow_dp[scan_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SCAN_BLANK;
         cnt      <= '0;
         scan_idx <= 2'd0;
         for (int k = 0; k < 4; k++) shadow[k] <= 4'h0;
         shadow_dp <= 4'h0;
         an       <= {4{ACTIVE_LOW}};
         seg      <= {7{ACTIVE_LOW}};
         dp       <= ACTIVE_LOW;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         scan_idx <= idx_nxt;
         if (sample && !bus.freeze) begin
            shadow[scan_idx]    <= bus.digit_in[scan_idx];
            shadow_dp[scan_idx] <= bus.dp_in[scan_idx];
         end
         an  <= an_act  ^ {4{ACTIVE_LOW}};
         seg <= seg_act ^ {7{ACTIVE_LOW}};
         dp  <= dp_act  ^ ACTIVE_LOW;
      end
   end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for the scanner with an 8-cycle slot and 2-cycle blanking gap.
module tb_seven_seg_scanner;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] scan_idx;
   int         tests = 0;
   int         fails = 0;

   seven_seg_scanner_if bus ();

   seven_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .scan_idx (scan_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_cycles(int n, logic [3:0] ea, logic [6:0] es, logic ed, string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_an"},  16'(an),  16'(ea));
         chk({tag, "_seg"}, 16'(seg), 16'(es));
         chk({tag, "_dp"},  16'(dp),  16'(ed));
      end
   endtask

   task automatic check_slot(int s, bit en, logic [6:0] es, logic ed);
      logic [3:0] ea;
      ea = 4'hF;
      if (en) ea[s] = 1'b0;
      expect_cycles(2, 4'hF, 7'h7F, 1'b1, "blank");
      chk("scan_idx", 16'(scan_idx), 16'(s));
      expect_cycles(6, ea, es, ed, "drive");
   endtask

   task automatic check_frame(logic [6:0] s0, logic [6:0] s1, logic [6:0] s2, logic [6:0] s3);
      check_slot(0, 1'b1, s0, 1'b1);
      check_slot(1, 1'b1, s1, 1'b1);
      check_slot(2, 1'b1, s2, 1'b1);
      check_slot(3, 1'b1, s3, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      bus.digit_in[0] = 4'h0;
      bus.digit_in[1] = 4'h1;
      bus.digit_in[2] = 4'hA;
      bus.digit_in[3] = 4'hF;
      bus.digit_en = 4'b1111;
      bus.dp_in    = 4'b0000;
      bus.freeze   = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_an",  16'(an),  16'hF);
         chk("rst_seg", 16'(seg), 16'h7F);
         chk("rst_dp",  16'(dp),  16'h1);
         chk("rst_idx", 16'(scan_idx), 16'h0);
      end
      reset = 1'b0;

      // basic scan order, two frames
      check_frame(7'h40, 7'h79, 7'h08, 7'h0E);
      check_frame(7'h40, 7'h79, 7'h08, 7'h0E);

      // mid-slot change of digit 0 must not tear the displayed code
      expect_cycles(2, 4'hF, 7'h7F, 1'b1, "mid_blank");
      expect_cycles(3, 4'b1110, 7'h40, 1'b1, "mid_pre");
      bus.digit_in[0] = 4'h8;
      expect_cycles(3, 4'b1110, 7'h40, 1'b1, "mid_post");
      check_slot(1, 1'b1, 7'h79, 1'b1);
      check_slot(2, 1'b1, 7'h08, 1'b1);
      check_slot(3, 1'b1, 7'h0E, 1'b1);
      check_frame(7'h00, 7'h79, 7'h08, 7'h0E);

      // freeze holds the shadow copy
      bus.freeze = 1'b1;
      bus.digit_in[0] = 4'h9;
      bus.digit_in[1] = 4'h7;
      bus.digit_in[2] = 4'h5;
      bus.digit_in[3] = 4'h3;
      check_frame(7'h00, 7'h79, 7'h08, 7'h0E);
      check_frame(7'h00, 7'h79, 7'h08, 7'h0E);
      bus.freeze = 1'b0;
      check_frame(7'h10, 7'h78, 7'h12, 7'h30);

      // freeze only on the sampling cycle of slot 1
      bus.digit_in[1] = 4'hC;
      check_slot(0, 1'b1, 7'h10, 1'b1);
      expect_cycles(1, 4'hF, 7'h7F, 1'b1, "fs_blank");
      bus.freeze = 1'b1;
      expect_cycles(1, 4'hF, 7'h7F, 1'b1, "fs_blank");
      bus.freeze = 1'b0;
      expect_cycles(6, 4'b1101, 7'h78, 1'b1, "fs_hold");
      check_slot(2, 1'b1, 7'h12, 1'b1);
      check_slot(3, 1'b1, 7'h30, 1'b1);
      check_frame(7'h10, 7'h46, 7'h12, 7'h30);

      // disabled digits keep their slot; dp on digit 0 only
      bus.digit_en = 4'b0101;
      bus.dp_in    = 4'b0001;
      check_slot(0, 1'b1, 7'h10, 1'b0);
      check_slot(1, 1'b0, 7'h46, 1'b1);
      check_slot(2, 1'b1, 7'h12, 1'b1);
      check_slot(3, 1'b0, 7'h30, 1'b1);

      // reset during slot 2 drive
      check_slot(0, 1'b1, 7'h10, 1'b0);
      check_slot(1, 1'b0, 7'h46, 1'b1);
      expect_cycles(2, 4'hF, 7'h7F, 1'b1, "pre_rst_blank");
      expect_cycles(3, 4'b1011, 7'h12, 1'b1, "pre_rst_drive");
      reset = 1'b1;
      tick();
      chk("mid_rst_an",  16'(an),  16'hF);
      chk("mid_rst_seg", 16'(seg), 16'h7F);
      chk("mid_rst_dp",  16'(dp),  16'h1);
      chk("mid_rst_idx", 16'(scan_idx), 16'h0);
      tick();
      reset = 1'b0;
      check_slot(0, 1'b1, 7'h10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
